// File: rtl/beacon_tdoa.sv
// rtl/beacon_tdoa.sv - multi-microphone beacon arrival-order (TDOA) detector with vote filter
module beacon_tdoa #(
  parameter int NUM_MICS   = 2,
  parameter int CNT_W      = 16,
  parameter int WIN_MIN    = 9200,
  parameter int WIN_MAX    = 10800,
  parameter int TIMEOUT    = 4000,
  parameter int HIST_DEPTH = 10,
  parameter int VOTE_TH    = 4,
  localparam int IDX_W     = ($clog2(NUM_MICS) > 1) ? $clog2(NUM_MICS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_MICS-1:0] mic,
  input  logic                enable,
  output logic                dir_valid,
  output logic [IDX_W-1:0]    lead_idx,
  output logic [CNT_W-1:0]    lag,
  output logic [IDX_W-1:0]    dir_filtered,
  output logic                timeout_err,
  output logic                width_err
);

  localparam int FILL_W = $clog2(HIST_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ARRIVE, MEASURE, REPORT} state_t;

  state_t              state;
  logic [NUM_MICS-1:0] sync1, sync2, sync_d;
  logic [NUM_MICS-1:0] rise, fall, new_rise, fall_n, arrived_n;
  logic [NUM_MICS-1:0] arrived, fallen;
  logic [CNT_W-1:0]    timer, timer_inc, lag_acc;
  logic [IDX_W-1:0]    lead_acc, lead_c, best_idx;
  logic [CNT_W-1:0]    wcnt [NUM_MICS];
  logic [IDX_W-1:0]    hist [HIST_DEPTH];
  logic [IDX_W-1:0]    hist_nx [HIST_DEPTH];
  logic [FILL_W-1:0]   fill, fill_nx, best_cnt;
  logic [FILL_W-1:0]   votes [NUM_MICS];
  logic                win_ok, sat_hi;

  assign rise      = sync2 & ~sync_d;
  assign fall      = ~sync2 & sync_d;
  assign timer_inc = timer + 1'b1;
  assign new_rise  = (state == ARRIVE) ? (rise & ~arrived) : '0;
  assign arrived_n = arrived | new_rise;
  assign fall_n    = fallen | (fall & arrived);
  assign fill_nx   = (fill == FILL_W'(HIST_DEPTH)) ? fill : fill + 1'b1;

  always_comb begin
    lead_c = '0;
    for (int c = NUM_MICS - 1; c >= 0; c--)
      if (rise[c]) lead_c = IDX_W'(c);
  end

  always_comb begin
    win_ok = 1'b1;
    sat_hi = 1'b0;
    for (int c = 0; c < NUM_MICS; c++) begin
      if (wcnt[c] < CNT_W'(WIN_MIN) || wcnt[c] > CNT_W'(WIN_MAX)) win_ok = 1'b0;
      if (sync2[c] && !fallen[c] && wcnt[c] == CNT_MAX) sat_hi = 1'b1;
    end
  end

  // Votes are taken over the history as it will look after this REPORT's push.
  always_comb begin
    hist_nx[0] = lead_acc;
    for (int i = 1; i < HIST_DEPTH; i++) hist_nx[i] = hist[i-1];
    best_idx = '0;
    best_cnt = '0;
    for (int c = 0; c < NUM_MICS; c++) begin
      votes[c] = '0;
      for (int i = 0; i < HIST_DEPTH; i++)
        if (FILL_W'(i) < fill_nx && hist_nx[i] == IDX_W'(c)) votes[c] = votes[c] + 1'b1;
      if (votes[c] > best_cnt) begin
        best_cnt = votes[c];
        best_idx = IDX_W'(c);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sync1        <= '0;
      sync2        <= '0;
      sync_d       <= '0;
      arrived      <= '0;
      fallen       <= '0;
      timer        <= '0;
      lag_acc      <= '0;
      lead_acc     <= '0;
      fill         <= '0;
      dir_valid    <= 1'b0;
      timeout_err  <= 1'b0;
      width_err    <= 1'b0;
      lead_idx     <= '0;
      lag          <= '0;
      dir_filtered <= '0;
      for (int c = 0; c < NUM_MICS; c++) wcnt[c] <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
    end else begin
      sync1       <= mic;
      sync2       <= sync1;
      sync_d      <= sync2;
      dir_valid   <= 1'b0;
      timeout_err <= 1'b0;
      width_err   <= 1'b0;

      if (state == ARRIVE || state == MEASURE) begin
        fallen <= fall_n;
        for (int c = 0; c < NUM_MICS; c++) begin
          if (new_rise[c])
            wcnt[c] <= CNT_W'(1);
          else if (arrived[c] && !fallen[c] && sync2[c] && wcnt[c] != CNT_MAX)
            wcnt[c] <= wcnt[c] + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (enable && |rise) begin
            state    <= ARRIVE;
            timer    <= '0;
            lag_acc  <= '0;
            lead_acc <= lead_c;
            arrived  <= rise;
            fallen   <= '0;
            for (int c = 0; c < NUM_MICS; c++) wcnt[c] <= rise[c] ? CNT_W'(1) : '0;
          end
        end
        ARRIVE: begin
          timer   <= timer_inc;
          arrived <= arrived_n;
          if (|new_rise) lag_acc <= timer_inc;
          // A channel landing exactly on the timeout cycle still completes the event.
          if (&arrived_n) begin
            state <= MEASURE;
          end else if (timer_inc == CNT_W'(TIMEOUT)) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end
        end
        MEASURE: begin
          if (sat_hi) begin
            width_err <= 1'b1;
            state     <= IDLE;
          end else if (&fall_n) begin
            if (win_ok) begin
              state     <= REPORT;
              dir_valid <= 1'b1;
              lead_idx  <= lead_acc;
              lag       <= lag_acc;
            end else begin
              width_err <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        REPORT: begin
          for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= hist_nx[i];
          fill <= fill_nx;
          if (best_cnt >= FILL_W'(VOTE_TH)) dir_filtered <= best_idx;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_beacon_tdoa.sv
// tb/tb_beacon_tdoa.sv - randomized self-checking bench for beacon_tdoa against an event-level model
module tb_beacon_tdoa;
  localparam int N    = 3;
  localparam int CW   = 8;
  localparam int WMIN = 92;
  localparam int WMAX = 108;
  localparam int TMO  = 60;
  localparam int HD   = 10;
  localparam int VT   = 4;
  localparam int IW   = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  mic;
  logic          enable;
  logic          dir_valid, timeout_err, width_err;
  logic [IW-1:0] lead_idx, dir_filtered;
  logic [CW-1:0] lag;

  beacon_tdoa #(
    .NUM_MICS(N), .CNT_W(CW), .WIN_MIN(WMIN), .WIN_MAX(WMAX),
    .TIMEOUT(TMO), .HIST_DEPTH(HD), .VOTE_TH(VT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mic(mic), .enable(enable),
    .dir_valid(dir_valid), .lead_idx(lead_idx), .lag(lag),
    .dir_filtered(dir_filtered), .timeout_err(timeout_err), .width_err(width_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Event-level model: history of accepted leads (newest first) and the voted direction.
  int hist_q[$];
  int model_filt = 0;

  function automatic void model_clear();
    hist_q.delete();
    model_filt = 0;
  endfunction

  function automatic void model_push(input int lead);
    int v [N];
    int best, bcnt;
    hist_q.push_front(lead);
    if (hist_q.size() > HD) void'(hist_q.pop_back());
    foreach (v[c]) v[c] = 0;
    foreach (hist_q[i]) v[hist_q[i]]++;
    best = 0;
    bcnt = 0;
    for (int c = 0; c < N; c++)
      if (v[c] > bcnt) begin
        bcnt = v[c];
        best = c;
      end
    if (bcnt >= VT) model_filt = best;
  endfunction

  int ev_off [N];  // arrival offset relative to the first channel, -1 = silent
  int ev_w   [N];

  task automatic run_event(input bit en, input bit drop_en, input string name);
    int kind, exp_lead, exp_lag, old_filt, tend, nv, nt, nw, got_lead, got_lag, t_tmo;
    bit silent, bad_w, pend;
    logic [N-1:0] m;
    exp_lag = 0; exp_lead = -1; silent = 0; bad_w = 0; tend = 0;
    for (int c = 0; c < N; c++) begin
      if (ev_off[c] < 0) silent = 1;
      else begin
        if (ev_off[c] == 0 && exp_lead < 0) exp_lead = c;
        if (ev_off[c] > exp_lag) exp_lag = ev_off[c];
        if (ev_w[c] < WMIN || ev_w[c] > WMAX) bad_w = 1;
        if (ev_off[c] + ev_w[c] > tend) tend = ev_off[c] + ev_w[c];
      end
    end
    tend = tend + 25;
    if (!en) kind = 0;
    else if (silent || exp_lag > TMO) kind = 2;
    else if (bad_w) kind = 3;
    else kind = 1;
    old_filt = model_filt;
    if (kind == 1) model_push(exp_lead);

    nv = 0; nt = 0; nw = 0; got_lead = 0; got_lag = 0; t_tmo = -1; pend = 0;
    enable = en;
    for (int t = 0; t <= tend; t++) begin
      @(negedge clk);
      if (dir_valid) begin
        nv++;
        got_lead = int'(lead_idx);
        got_lag  = int'(lag);
        check({name, "_filt_hold"}, dir_filtered, old_filt);
        pend = 1;
      end else if (pend) begin
        check({name, "_filt_new"}, dir_filtered, model_filt);
        pend = 0;
      end
      if (timeout_err) begin
        nt++;
        t_tmo = t;
      end
      if (width_err) nw++;
      for (int c = 0; c < N; c++)
        m[c] = (ev_off[c] >= 0 && t >= ev_off[c] && t < ev_off[c] + ev_w[c]);
      mic = m;
      if (drop_en && t == 8) enable = 1'b0;
    end
    mic = '0;
    enable = 1'b1;
    check({name, "_n_valid"}, nv, (kind == 1) ? 1 : 0);
    check({name, "_n_timeout"}, nt, (kind == 2) ? 1 : 0);
    check({name, "_n_width"}, nw, (kind == 3) ? 1 : 0);
    if (kind == 1) begin
      check({name, "_lead"}, got_lead, exp_lead);
      check({name, "_lag"}, got_lag, exp_lag);
    end
    if (kind == 2) check({name, "_tmo_time"}, t_tmo, TMO + 3);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_dir_valid"}, dir_valid, 0);
    check({name, "_timeout_err"}, timeout_err, 0);
    check({name, "_width_err"}, width_err, 0);
    check({name, "_lead_idx"}, lead_idx, 0);
    check({name, "_lag"}, lag, 0);
    check({name, "_dir_filtered"}, dir_filtered, 0);
  endtask

  // Starts an event, asserts reset once it is well inside the width measurement, then recovers.
  task automatic reset_mid(input string name);
    mic = '0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      mic = (t >= 3) ? 3'b111 : 3'b010;
    end
    #2 rst_n = 1'b0;
    mic = '0;
    model_clear();
    repeat (2) @(negedge clk);
    check_reset_outputs(name);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check_reset_outputs({name, "_post"});
  endtask

  initial begin
    rst_n = 1'b0;
    mic = '0;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    ev_off = '{50, 0, 30};  ev_w = '{100, 100, 100}; run_event(1, 0, "lead1_lag50");
    ev_off = '{0, 0, 0};    ev_w = '{100, 100, 100}; run_event(1, 0, "simultaneous");
    ev_off = '{0, -1, 10};  ev_w = '{100, 100, 100}; run_event(1, 0, "silent_ch");
    ev_off = '{0, 5, 9};    ev_w = '{91, 100, 100};  run_event(1, 0, "width_short");
    ev_off = '{0, 5, 9};    ev_w = '{92, 108, 100};  run_event(1, 0, "width_edges");
    ev_off = '{7, 0, 9};    ev_w = '{100, 109, 100}; run_event(1, 0, "width_long");
    ev_off = '{7, 0, 9};    ev_w = '{100, 100, 300}; run_event(1, 0, "width_sat");
    ev_off = '{0, TMO, 9};  ev_w = '{100, 100, 100}; run_event(1, 0, "lag_at_tmo");
    ev_off = '{3, 0, 9};    ev_w = '{100, 100, 100}; run_event(0, 0, "disabled");
    ev_off = '{3, 0, 20};   ev_w = '{100, 100, 100}; run_event(1, 1, "enable_drop");

    reset_mid("reset_mid1");
    ev_off = '{10, 0, 25};  ev_w = '{100, 100, 100};
    for (int k = 0; k < 3; k++) run_event(1, 0, "vote_pre");
    check("vote_three_hold", dir_filtered, 0);
    run_event(1, 0, "vote_fourth");
    check("vote_fourth_dir", dir_filtered, 1);
    reset_mid("reset_mid2");

    for (int k = 0; k < 40; k++) begin
      int mn;
      mn = 1000;
      for (int c = 0; c < N; c++) begin
        ev_off[c] = ($urandom_range(0, 11) == 0) ? -1 : int'($urandom_range(0, TMO));
        ev_w[c]   = ($urandom_range(0, 15) == 0) ? 300 : int'($urandom_range(WMIN - 3, WMAX + 3));
      end
      if (ev_off[0] < 0 && ev_off[1] < 0 && ev_off[2] < 0) ev_off[0] = 0;
      for (int c = 0; c < N; c++) if (ev_off[c] >= 0 && ev_off[c] < mn) mn = ev_off[c];
      for (int c = 0; c < N; c++) if (ev_off[c] >= 0) ev_off[c] = ev_off[c] - mn;
      run_event(1, 0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
